// File: rtl/rx_bit_timer.sv
// Receive bit-timing controller: tracks bit phase from line transitions, issues
// mid-bit sample strobes, counts bits per byte and aborts on missing transitions.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for enable together with a line transition
// RUN   | phase counter locked to the line, sample strobes issued per bit
module rx_bit_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_POINT  = 3,
    parameter int BITS_PER_BYTE = 8,
    parameter int MAX_RUN_BITS  = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       d_edge,
    input  logic       d_bit,
    output logic       shift_strobe,
    output logic       sample_bit,
    output logic [3:0] bit_count,
    output logic       byte_done,
    output logic       rx_active,
    output logic       run_error
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_POINT);
    localparam logic [PW-1:0] PH_ONE    = PW'(1);
    localparam logic [3:0]    RUN_MAX   = 4'(MAX_RUN_BITS);
    localparam logic [3:0]    BYTE_LEN  = 4'(BITS_PER_BYTE);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] phase;
    logic [3:0]    run_cnt;
    logic [3:0]    bit_next;

    assign bit_next = bit_count + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= '0;
            run_cnt      <= '0;
            bit_count    <= '0;
            shift_strobe <= 1'b0;
            sample_bit   <= 1'b0;
            byte_done    <= 1'b0;
            rx_active    <= 1'b0;
            run_error    <= 1'b0;
        end else begin
            shift_strobe <= 1'b0;
            byte_done    <= 1'b0;
            run_error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && d_edge) begin
                        state     <= RUN;
                        phase     <= PH_ONE;
                        run_cnt   <= '0;
                        bit_count <= '0;
                        rx_active <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state     <= IDLE;
                        rx_active <= 1'b0;
                        bit_count <= '0;
                    end else if (d_edge) begin
                        // a transition re-centres the bit period; it also wins over a sample
                        phase   <= PH_ONE;
                        run_cnt <= '0;
                    end else begin
                        phase <= (phase == PH_LAST) ? '0 : phase + PH_ONE;
                        if (phase == PH_SAMPLE) begin
                            if (run_cnt < RUN_MAX) begin
                                shift_strobe <= 1'b1;
                                sample_bit   <= d_bit;
                                run_cnt      <= run_cnt + 4'd1;
                                if (bit_next == BYTE_LEN) begin
                                    bit_count <= '0;
                                    byte_done <= 1'b1;
                                end else begin
                                    bit_count <= bit_next;
                                end
                            end else begin
                                state     <= IDLE;
                                rx_active <= 1'b0;
                                bit_count <= '0;
                                run_error <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Scoreboard bench for rx_bit_timer: directed edge patterns push expected pulse
// events and level snapshots; a negedge monitor pops and compares them.
module tb_rx_bit_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       d_edge = 1'b0;
    logic       d_bit = 1'b0;
    logic       shift_strobe;
    logic       sample_bit;
    logic [3:0] bit_count;
    logic       byte_done;
    logic       rx_active;
    logic       run_error;

    rx_bit_timer dut (
        .clk(clk), .rst(rst), .enable(enable), .d_edge(d_edge), .d_bit(d_bit),
        .shift_strobe(shift_strobe), .sample_bit(sample_bit), .bit_count(bit_count),
        .byte_done(byte_done), .rx_active(rx_active), .run_error(run_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int base = 0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic       st;
        logic       bd;
        logic       er;
        logic       sb;
        logic [3:0] bc;
    } pulse_t;

    typedef struct {
        int         c;
        logic       act;
        logic [3:0] bc;
        logic       sb;
    } level_t;

    pulse_t pq[$];
    level_t lq[$];

    task automatic exp_pulse(input int c, input logic st, input logic bd, input logic er,
                             input logic sb, input logic [3:0] bc);
        pulse_t p;
        p.c = base + c; p.st = st; p.bd = bd; p.er = er; p.sb = sb; p.bc = bc;
        pq.push_back(p);
    endtask

    task automatic exp_level(input int c, input logic act, input logic [3:0] bc, input logic sb);
        level_t l;
        l.c = base + c; l.act = act; l.bc = bc; l.sb = sb;
        lq.push_back(l);
    endtask

    // monitor: pulses are matched against the pulse queue, levels at their scheduled cycle
    always @(negedge clk) begin
        pulse_t p;
        level_t l;
        while (pq.size() > 0 && pq[0].c < cyc) begin
            p = pq.pop_front();
            n_cmp++; n_err++;
            $display("FAIL pulse_missing cycle=%0d: no pulse seen, expected st=%b bd=%b er=%b",
                     p.c - base, p.st, p.bd, p.er);
        end
        if (shift_strobe || byte_done || run_error) begin
            n_cmp++;
            if (pq.size() == 0 || pq[0].c != cyc) begin
                n_err++;
                $display("FAIL pulse_unexpected cycle=%0d: got st=%b bd=%b er=%b, expected none",
                         cyc - base, shift_strobe, byte_done, run_error);
            end else begin
                p = pq.pop_front();
                if ({shift_strobe, byte_done, run_error, sample_bit, bit_count} !==
                    {p.st, p.bd, p.er, p.sb, p.bc}) begin
                    n_err++;
                    $display("FAIL pulse_value cycle=%0d: got st=%b bd=%b er=%b sb=%b bc=%0d, expected st=%b bd=%b er=%b sb=%b bc=%0d",
                             cyc - base, shift_strobe, byte_done, run_error, sample_bit, bit_count,
                             p.st, p.bd, p.er, p.sb, p.bc);
                end
            end
        end
        while (lq.size() > 0 && lq[0].c <= cyc) begin
            l = lq.pop_front();
            n_cmp++;
            if (l.c != cyc || {rx_active, bit_count, sample_bit} !== {l.act, l.bc, l.sb}) begin
                n_err++;
                $display("FAIL level cycle=%0d: got act=%b bc=%0d sb=%b, expected act=%b bc=%0d sb=%b",
                         l.c - base, rx_active, bit_count, sample_bit, l.act, l.bc, l.sb);
            end
        end
    end

    task automatic at(input int n);
        while (cyc < base + n) @(negedge clk);
    endtask

    task automatic pulse_edge(input int n);
        at(n);
        d_edge = 1'b1;
        at(n + 1);
        d_edge = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; d_edge = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        base = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // basic run: three strobes, then enable drop
        do_reset();
        exp_level(1, 0, 0, 0);
        exp_level(11, 1, 0, 0);
        exp_pulse(14, 1, 0, 0, 1, 1);
        exp_pulse(22, 1, 0, 0, 1, 2);
        exp_pulse(30, 1, 0, 0, 1, 3);
        exp_level(31, 1, 3, 1);
        exp_level(33, 0, 0, 1);
        enable = 1'b1; d_bit = 1'b1;
        pulse_edge(10);
        at(32); enable = 1'b0;
        at(36);

        // early resync edge
        do_reset();
        exp_level(1, 0, 0, 0);
        exp_pulse(14, 1, 0, 0, 0, 1);
        exp_pulse(20, 1, 0, 0, 0, 2);
        exp_level(27, 0, 0, 0);
        enable = 1'b1; d_bit = 1'b0;
        pulse_edge(10);
        pulse_edge(16);
        at(26); enable = 1'b0;
        at(30);

        // edge on the sample phase, then enable drop on a sample phase
        do_reset();
        exp_pulse(17, 1, 0, 0, 1, 1);
        exp_level(25, 0, 0, 1);
        enable = 1'b1; d_bit = 1'b1;
        pulse_edge(10);
        pulse_edge(13);
        at(24); enable = 1'b0;
        at(30);

        // full byte with alternating data
        do_reset();
        for (int k = 0; k < 8; k++)
            exp_pulse(14 + 8 * k, 1, (k == 7), 0, (k % 2 == 0), (k == 7) ? 4'd0 : 4'(k + 1));
        exp_level(71, 1, 0, 0);
        exp_level(73, 0, 0, 0);
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            at(10 + 8 * k);
            d_bit = (k % 2 == 0);
            pulse_edge(10 + 8 * k);
        end
        at(72); enable = 1'b0;
        at(76);

        // missing transitions -> run_error, then restart
        do_reset();
        for (int k = 0; k < 7; k++)
            exp_pulse(14 + 8 * k, 1, 0, 0, 0, 4'(k + 1));
        exp_pulse(70, 0, 0, 1, 0, 0);
        exp_level(70, 0, 0, 0);
        exp_level(76, 1, 0, 0);
        exp_pulse(79, 1, 0, 0, 1, 1);
        exp_level(81, 0, 0, 1);
        enable = 1'b1; d_bit = 1'b0;
        pulse_edge(10);
        at(72); d_bit = 1'b1;
        pulse_edge(75);
        at(80); enable = 1'b0;
        at(84);

        // enable drop mid-byte, then ignored edge while disabled
        do_reset();
        for (int k = 0; k < 5; k++)
            exp_pulse(6 + 8 * k, 1, 0, 0, 1, 4'(k + 1));
        exp_level(40, 1, 5, 1);
        exp_level(41, 0, 0, 1);
        exp_level(45, 0, 0, 1);
        exp_level(49, 0, 0, 1);
        enable = 1'b1; d_bit = 1'b1;
        pulse_edge(2);
        at(40); enable = 1'b0;
        pulse_edge(44);
        at(52);

        // synchronous reset on a sample phase
        do_reset();
        exp_pulse(14, 1, 0, 0, 1, 1);
        exp_level(22, 0, 0, 0);
        exp_level(30, 0, 0, 0);
        enable = 1'b1; d_bit = 1'b1;
        pulse_edge(10);
        at(21); rst = 1'b1;
        at(22); rst = 1'b0;
        at(32);
        enable = 1'b0;

        repeat (4) @(negedge clk);
        while (pq.size() > 0) begin
            pulse_t p;
            p = pq.pop_front();
            n_cmp++; n_err++;
            $display("FAIL pulse_leftover: expected pulse at cycle %0d never seen", p.c - base);
        end
        while (lq.size() > 0) begin
            level_t l;
            l = lq.pop_front();
            n_cmp++; n_err++;
            $display("FAIL level_leftover: level check at cycle %0d never reached", l.c - base);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
